div_result_bcd: RTL and testbench
=================================

# div_result_bcd

Downstream consumer of the 4-bit sequential divider's packed {remainder, quotient} result. It converts both fields to packed BCD for display/logging with a shared, iterative double-dabble datapath, one binary bit per clock. It takes results over a valid/ready handshake and holds its BCD outputs until the sink accepts them.

## Interface
- DW, default 4: width of quotient and of remainder. Legal range 4..8.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- in_valid  in  1  divider result present.
- in_ready  out  1  block can accept a result this cycle.
- in_quo  in  DW  quotient, unsigned.
- in_rem  in  DW  remainder, unsigned.
- out_valid  out  1  BCD results present.
- out_ready  in  1  sink accepts results.
- out_quo_bcd  out  12  quotient as 3 packed BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones.
- out_rem_bcd  out  12  remainder, same packing.
- busy  out  1  conversion in progress (CONV_Q or CONV_R).

## Operation
- FSM states: IDLE, CONV_Q, CONV_R, DONE. Reset state is IDLE.
- in_ready is combinational: it is 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise.
- Accept means in_valid && in_ready at a rising edge. On accept:
  - capture in_rem into a hold register;
  - load the shift register with in_quo, clear the BCD accumulator, clear the counter;
  - go to CONV_Q.
- Per step, in CONV_Q or CONV_R:
  - each BCD digit ≥5 gets +3;
  - then {acc, shift} is shifted left by 1 (MSB of shift enters acc bit 0);
  - counter increments.
- After step DW in CONV_Q:
  - register the accumulator into out_quo_bcd;
  - reload the shift register from the hold register, clear acc and counter;
  - go to CONV_R.
- After step DW in CONV_R:
  - register the accumulator into out_rem_bcd;
  - set out_valid=1;
  - go to DONE.
- DONE with out_ready=0: out_valid and both BCD outputs hold stable.
- DONE with out_ready=1: output transfer. If in_valid=1 on the same edge, the new result is accepted (→CONV_Q), otherwise →IDLE. out_valid clears on that edge either way.
- in_valid while busy: ignored (in_ready=0). The upstream divider must hold its result.
- Arithmetic is unsigned. For DW=4 the hundreds digit is always 0. Maximum value 255 (DW=8) fits in 3 digits.
- Counter is 4 bits. It never wraps, because a phase terminates at count DW.

## Timing
- Reset values: out_valid=0, out_quo_bcd=0, out_rem_bcd=0, busy=0. in_ready=1 (IDLE).
- Latency: accept at edge E0 gives out_valid=1 after edge E0+2·DW (E8 for DW=4).
- out_quo_bcd updates at edge E0+DW and is stable from then on. Both outputs are stable whenever out_valid=1.
- Throughput with out_ready tied high: one result per 2·DW+1 cycles (9 for DW=4). out_valid pulses high for 1 cycle.
- busy=1 exactly for the 2·DW cycles after accept.
- Reset assertion at any time, including mid-CONV_Q/CONV_R or DONE with a pending output:
  - immediately forces IDLE;
  - all outputs go to their reset values;
  - the partial result is discarded, with no spurious out_valid after release.
- First accept is possible on the first rising edge after n_rst deasserts.

## Structure
- Shared package div_pkg holds:
  - state enum DIV_BCD_IDLE/CONV_Q/CONV_R/DONE;
  - localparam BCD_DIGITS=3;
  - BCD_W=12;
  - constant 4'd5 threshold and 4'd3 correction.
- One sub-module, bcd_dd_step: combinational. It takes a 12-bit acc plus 1 incoming bit and returns the corrected, shifted 12-bit acc. It is instantiated once and shared by both phases.
- Top holds the FSM, counter, shift/hold registers and output registers.

## Test plan
- Reset release, then in_quo=13, in_rem=2, out_ready=1 → out_valid at E8; out_quo_bcd=0x013, out_rem_bcd=0x002; busy high 8 cycles.
- in_quo=15, in_rem=15 → both outputs 0x015. in_quo=0, in_rem=0 → both 0x000, with same latency.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs and out_valid held; in_ready=0 and in_valid ignored; out_ready=1 → transfer then IDLE.
- Back-to-back:
  - in_valid held high with 7/3 then 9/1, out_ready=1;
  - second accept on the same edge as the first transfer;
  - results 0x007/0x003 then 0x009/0x001, 9 cycles apart.
- Reset mid-CONV_R (edge E6) → outputs 0, IDLE. Next request 10/5 → 0x010/0x005 with full latency.
- DW=8 build: in_quo=255, in_rem=128 → 0x255/0x128 at E16.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider-result BCD converter.
package div_pkg;
  typedef enum logic [1:0] {
    DIV_BCD_IDLE,
    DIV_BCD_CONV_Q,
    DIV_BCD_CONV_R,
    DIV_BCD_DONE
  } div_bcd_state_t;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam logic [3:0] DD_THRESH = 4'd5;
  localparam logic [3:0] DD_CORR = 4'd3;
endpackage

// File: rtl/bcd_dd_step.sv
// bcd_dd_step: one double-dabble iteration (add-3 correction, then shift in one bit).
module bcd_dd_step
  import div_pkg::*;
(
  input  logic [BCD_W-1:0] acc,
  input  logic             bit_in,
  output logic [BCD_W-1:0] acc_next
);
  logic [BCD_W-1:0] corr;
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    assign corr[4*g+:4] = acc[4*g+:4] >= DD_THRESH ? acc[4*g+:4] + DD_CORR : acc[4*g+:4];
  end
  assign acc_next = (corr << 1) | {{(BCD_W-1){1'b0}}, bit_in};
endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: converts a {remainder, quotient} divider result to packed BCD,
// quotient first then remainder, one bit per clock through a shared double-dabble step.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_quo,
  input  logic [DW-1:0]    in_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] out_quo_bcd,
  output logic [BCD_W-1:0] out_rem_bcd,
  output logic             busy
);
  localparam logic [3:0] LAST = 4'(DW - 1);
  div_bcd_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [DW-1:0] shift, hold;
  logic [BCD_W-1:0] acc, acc_step;
  logic accept, last;
  assign accept = in_valid && in_ready;
  assign last = cnt == LAST;
  bcd_dd_step u_step (
    .acc     (acc),
    .bit_in  (shift[DW-1]),
    .acc_next(acc_step)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= DIV_BCD_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_BCD_IDLE:   state_nxt = in_valid ? DIV_BCD_CONV_Q : DIV_BCD_IDLE;
      DIV_BCD_CONV_Q: state_nxt = last ? DIV_BCD_CONV_R : DIV_BCD_CONV_Q;
      DIV_BCD_CONV_R: state_nxt = last ? DIV_BCD_DONE : DIV_BCD_CONV_R;
      DIV_BCD_DONE:   state_nxt = !out_ready ? DIV_BCD_DONE : in_valid ? DIV_BCD_CONV_Q : DIV_BCD_IDLE;
      default:        state_nxt = DIV_BCD_IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == DIV_BCD_IDLE || (state == DIV_BCD_DONE && out_ready);
    busy      = state == DIV_BCD_CONV_Q || state == DIV_BCD_CONV_R;
    out_valid = state == DIV_BCD_DONE;
  end
  // The last step of each phase bypasses acc and lands directly in the output register.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt         <= '0;
      shift       <= '0;
      hold        <= '0;
      acc         <= '0;
      out_quo_bcd <= '0;
      out_rem_bcd <= '0;
    end else if (accept) begin
      hold  <= in_rem;
      shift <= in_quo;
      acc   <= '0;
      cnt   <= '0;
    end else if (busy && last) begin
      shift <= hold;
      acc   <= '0;
      cnt   <= '0;
      if (state == DIV_BCD_CONV_Q) out_quo_bcd <= acc_step;
      else out_rem_bcd <= acc_step;
    end else if (busy) begin
      acc   <= acc_step;
      shift <= shift << 1;
      cnt   <= cnt + 4'd1;
    end
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed table-driven checks of the BCD converter at DW=4 and DW=8.
module tb_div_result_bcd;
  logic clk = 1'b0;
  logic n_rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_quo, in_rem;
  logic [11:0] out_quo_bcd, out_rem_bcd;
  logic iv8, ir8, ov8, or8, busy8;
  logic [7:0] q8, r8;
  logic [11:0] oq8, orr8;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_result_bcd #(.DW(4)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_quo(in_quo), .in_rem(in_rem), .out_valid(out_valid), .out_ready(out_ready),
    .out_quo_bcd(out_quo_bcd), .out_rem_bcd(out_rem_bcd), .busy(busy)
  );

  div_result_bcd #(.DW(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv8), .in_ready(ir8),
    .in_quo(q8), .in_rem(r8), .out_valid(ov8), .out_ready(or8),
    .out_quo_bcd(oq8), .out_rem_bcd(orr8), .busy(busy8)
  );

  typedef struct {
    logic [3:0]  quo;
    logic [3:0]  rem;
    logic [11:0] exp_q;
    logic [11:0] exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one result, then track busy and latency until out_valid (out_ready held high).
  task automatic run4(input logic [3:0] q, input logic [3:0] r,
                      input logic [11:0] eq, input logic [11:0] er);
    int cyc, bc;
    chk("in_ready_idle", 32'(in_ready), 1);
    in_quo = q;
    in_rem = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    bc = 0;
    while (!out_valid && cyc < 40) begin
      bc += int'(busy);
      tick();
      cyc++;
    end
    chk("latency4", 32'(cyc), 8);
    chk("busy_cycles4", 32'(bc), 8);
    chk("quo_bcd4", 32'(out_quo_bcd), 32'(eq));
    chk("rem_bcd4", 32'(out_rem_bcd), 32'(er));
    chk("busy_in_done", 32'(busy), 0);
    tick();
    chk("valid_pulse", 32'(out_valid), 0);
  endtask

  task automatic run8(input logic [7:0] q, input logic [7:0] r,
                      input logic [11:0] eq, input logic [11:0] er);
    int cyc;
    q8 = q;
    r8 = r;
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("latency8", 32'(cyc), 16);
    chk("quo_bcd8", 32'(oq8), 32'(eq));
    chk("rem_bcd8", 32'(orr8), 32'(er));
    tick();
  endtask

  initial begin
    vec_t vecs[8];
    int cyc, t_first;
    vecs[0] = '{4'd13, 4'd2,  12'h013, 12'h002};
    vecs[1] = '{4'd15, 4'd15, 12'h015, 12'h015};
    vecs[2] = '{4'd0,  4'd0,  12'h000, 12'h000};
    vecs[3] = '{4'd12, 4'd9,  12'h012, 12'h009};
    vecs[4] = '{4'd4,  4'd11, 12'h004, 12'h011};
    vecs[5] = '{4'd5,  4'd10, 12'h005, 12'h010};
    vecs[6] = '{4'd1,  4'd8,  12'h001, 12'h008};
    vecs[7] = '{4'd9,  4'd14, 12'h009, 12'h014};
    n_rst = 1'b0;
    in_valid = 1'b0;
    in_quo = '0;
    in_rem = '0;
    out_ready = 1'b1;
    iv8 = 1'b0;
    q8 = '0;
    r8 = '0;
    or8 = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_quo", 32'(out_quo_bcd), 0);
    chk("rst_rem", 32'(out_rem_bcd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) run4(vecs[i].quo, vecs[i].rem, vecs[i].exp_q, vecs[i].exp_r);

    // Backpressure: result held while in_valid is presented and ignored.
    out_ready = 1'b0;
    in_quo = 4'd11;
    in_rem = 4'd6;
    in_valid = 1'b1;
    tick();
    in_quo = 4'd2;
    in_rem = 4'd2;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_quo_held", 32'(out_quo_bcd), 32'h011);
      chk("bp_rem_held", 32'(out_rem_bcd), 32'h006);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_transfer_valid", 32'(out_valid), 0);
    chk("bp_idle_ready", 32'(in_ready), 1);
    chk("bp_idle_busy", 32'(busy), 0);

    // Back-to-back: second result accepted on the edge that transfers the first.
    in_quo = 4'd7;
    in_rem = 4'd3;
    in_valid = 1'b1;
    tick();
    in_quo = 4'd9;
    in_rem = 4'd1;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    t_first = cyc;
    chk("b2b_lat1", 32'(cyc), 8);
    chk("b2b_quo1", 32'(out_quo_bcd), 32'h007);
    chk("b2b_rem1", 32'(out_rem_bcd), 32'h003);
    tick();
    in_valid = 1'b0;
    cyc++;
    chk("b2b_accepted", 32'(busy), 1);
    while (!out_valid && cyc < 80) begin
      tick();
      cyc++;
    end
    chk("b2b_spacing", 32'(cyc - t_first), 9);
    chk("b2b_quo2", 32'(out_quo_bcd), 32'h009);
    chk("b2b_rem2", 32'(out_rem_bcd), 32'h001);
    tick();
    chk("b2b_end_valid", 32'(out_valid), 0);

    // Reset during CONV_R discards the conversion.
    in_quo = 4'd14;
    in_rem = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("mid_quo_ready", 32'(out_quo_bcd), 32'h014);
    chk("mid_busy", 32'(busy), 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_quo", 32'(out_quo_bcd), 0);
    chk("mid_rst_rem", 32'(out_rem_bcd), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    n_rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cyc += int'(out_valid) + int'(busy);
    end
    chk("no_spurious", 32'(cyc), 0);
    run4(4'd10, 4'd5, 12'h010, 12'h005);

    run8(8'd255, 8'd128, 12'h255, 12'h128);
    run8(8'd200, 8'd99, 12'h200, 12'h099);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
